// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O peripherals: register addresses,
// pin positions and operator codes.
package io_pkg;

    localparam logic [3:0] ADDR_SW_LO = 4'd3;
    localparam logic [3:0] ADDR_SW_HI = 4'd4;
    localparam logic [3:0] ADDR_OP    = 4'd5;
    localparam logic [3:0] ADDR_EVT   = 4'd6;
    localparam logic [3:0] ADDR_CNT   = 4'd7;

    localparam int NUM_SW   = 10;
    localparam int NUM_BTN  = 3;
    localparam int NUM_PINS = NUM_SW + NUM_BTN;
    localparam int BTN_BASE = NUM_SW;
    localparam int BTN_0    = 0;
    localparam int BTN_1    = 1;
    localparam int BTN_2    = 2;

    typedef enum logic [1:0] {
        OP_0 = 2'b00,
        OP_1 = 2'b01,
        OP_2 = 2'b10
    } op_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, debounce counter and stable flop.
// fall pulses during the cycle whose closing edge moves stable from 1 to 0.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   CNT_WIDTH       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic fall
);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 stable_q, stable_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = pin;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        fall     = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                fall     = stable_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_input_capture.sv
// Debounced switch/button capture with sticky press events and a press counter,
// exposed through the shared I/O register window with a registered read port.
module io_input_capture
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    input  logic [12:0] io_bus_in,
    output logic [31:0] data_out,
    output logic        event_pending
);

    logic [NUM_PINS-1:0] stable_w;
    logic [NUM_PINS-1:0] fall_w;

    generate
        for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (gi >= BTN_BASE),
                .CNT_WIDTH       (CNT_WIDTH)
            ) u_db (
                .clock  (clock),
                .reset  (reset),
                .pin    (io_bus_in[gi]),
                .stable (stable_w[gi]),
                .fall   (fall_w[gi])
            );
        end
    endgenerate

    logic [2:0]  events_q, events_d;
    logic [15:0] press_count_q, press_count_d;
    op_e         operator_q, operator_d;
    logic [31:0] data_out_q, data_out_d;
    logic        pending_q, pending_d;

    logic [2:0]  btn_fall;
    logic [15:0] n_press;
    logic        wr_evt, wr_cnt;
    logic        unused_data_bits;

    assign unused_data_bits = ^data_in[31:3];

    always_comb begin
        btn_fall = fall_w[BTN_BASE +: NUM_BTN];
        n_press  = {14'b0, popcount3(btn_fall)};
        wr_evt   = write_enable && (addr == ADDR_EVT);
        wr_cnt   = write_enable && (addr == ADDR_CNT);

        // A press on the clearing edge survives both the W1C and the count clear.
        events_d      = (events_q & ~(wr_evt ? data_in[2:0] : 3'b000)) | btn_fall;
        press_count_d = wr_cnt ? n_press : press_count_q + n_press;

        operator_d = operator_q;
        if (btn_fall[BTN_0])      operator_d = OP_0;
        else if (btn_fall[BTN_1]) operator_d = OP_1;
        else if (btn_fall[BTN_2]) operator_d = OP_2;

        data_out_d = 32'h0;
        case (addr)
            ADDR_SW_LO: data_out_d = {27'b0, stable_w[4:0]};
            ADDR_SW_HI: data_out_d = {27'b0, stable_w[9:5]};
            ADDR_OP:    data_out_d = {30'b0, operator_q};
            ADDR_EVT:   data_out_d = {29'b0, events_q};
            ADDR_CNT:   data_out_d = {16'b0, press_count_q};
            default:    data_out_d = 32'h0;
        endcase

        pending_d = |events_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            events_q      <= 3'b000;
            press_count_q <= 16'h0000;
            operator_q    <= OP_0;
            data_out_q    <= 32'h0;
            pending_q     <= 1'b0;
        end else begin
            events_q      <= events_d;
            press_count_q <= press_count_d;
            operator_q    <= operator_d;
            data_out_q    <= data_out_d;
            pending_q     <= pending_d;
        end
    end

    assign data_out      = data_out_q;
    assign event_pending = pending_q;

endmodule

// File: tb/tb_io_input_capture.sv
// Bench for io_input_capture: window-based reference model checked every cycle,
// directed literal checks, and a fast-debounce instance for the counter wrap.
module tb_io_input_capture;

    localparam int D = 4;
    localparam logic [12:0] RST_WORD = 13'h1C00;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [3:0]  addr, addr2;
    logic [31:0] din, din2;
    logic        we, we2;
    logic [12:0] io, io2;
    logic [31:0] dout, dout2;
    logic        pend, pend2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    io_input_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clk), .reset(rst), .addr(addr), .data_in(din),
        .write_enable(we), .io_bus_in(io), .data_out(dout), .event_pending(pend)
    );

    io_input_capture #(.DEBOUNCE_CYCLES(1)) u_wrap (
        .clock(clk), .reset(rst2), .addr(addr2), .data_in(din2),
        .write_enable(we2), .io_bus_in(io2), .data_out(dout2), .event_pending(pend2)
    );

    // ---------------- reference model ----------------
    logic [12:0] hist[$];
    logic [12:0] m_st;
    int          m_last[13];
    logic [2:0]  m_evt;
    logic [15:0] m_cnt;
    logic [1:0]  m_op;
    logic [31:0] exp_dout;
    logic        exp_pend;
    logic        m_valid = 1'b0;
    logic [2:0]  m_fell;
    int          m_k;
    bit          m_all;

    // Synchronized value presented to the debouncer before edge j (edges since reset).
    function automatic logic sync_at(int j, int i);
        logic [12:0] w;
        if (j >= 3) w = hist[j-3];
        else        w = RST_WORD;
        return w[i];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_st = RST_WORD;
            for (int i = 0; i < 13; i++) m_last[i] = -1000;
            m_evt = 3'b0; m_cnt = 16'h0; m_op = 2'b00;
            exp_dout = 32'h0; exp_pend = 1'b0;
            m_valid = 1'b1;
        end else begin
            case (addr)
                4'd3:    exp_dout = {27'b0, m_st[4:0]};
                4'd4:    exp_dout = {27'b0, m_st[9:5]};
                4'd5:    exp_dout = {30'b0, m_op};
                4'd6:    exp_dout = {29'b0, m_evt};
                4'd7:    exp_dout = {16'b0, m_cnt};
                default: exp_dout = 32'h0;
            endcase
            exp_pend = (m_evt != 3'b0);
            hist.push_back(io);
            m_k = hist.size();
            m_fell = 3'b0;
            for (int i = 0; i < 13; i++) begin
                // Flip once the last D synchronized samples all disagree with stable.
                m_all = (m_k - D + 1 >= 1) && (m_last[i] <= m_k - D);
                for (int j = m_k - D + 1; j <= m_k; j++)
                    if (j >= 1 && sync_at(j, i) == m_st[i]) m_all = 0;
                if (m_all) begin
                    if (i >= 10 && m_st[i]) m_fell[i-10] = 1'b1;
                    m_st[i] = ~m_st[i];
                    m_last[i] = m_k;
                end
            end
            if (we && addr == 4'd6) m_evt = m_evt & ~din[2:0];
            m_evt = m_evt | m_fell;
            if (we && addr == 4'd7) m_cnt = 16'($countones(m_fell));
            else                    m_cnt = m_cnt + 16'($countones(m_fell));
            if (m_fell[0])      m_op = 2'b00;
            else if (m_fell[1]) m_op = 2'b01;
            else if (m_fell[2]) m_op = 2'b10;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (dout !== exp_dout) begin
                miscompares++;
                $display("FAIL model_data_out t=%0t addr=%0d got=%h exp=%h", $time, addr, dout, exp_dout);
            end
            vectors++;
            if (pend !== exp_pend) begin
                miscompares++;
                $display("FAIL model_event_pending t=%0t got=%b exp=%b", $time, pend, exp_pend);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic rd(input logic [3:0] a, input string name, input logic [31:0] expv);
        addr = a;
        step(1);
        check(name, dout, expv);
    endtask

    task automatic rd2(input logic [3:0] a, input string name, input logic [31:0] expv);
        addr2 = a;
        step(1);
        check(name, dout2, expv);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        addr = 4'd0; addr2 = 4'd0; din = 32'h0; din2 = 32'h0; we = 1'b0; we2 = 1'b0;
        io = 13'h1FFF; io2 = 13'h1C00;
        step(3);
        rst = 1'b0;

        // Reset state, then switches appear after 2+D edges.
        rd(4'd3, "rst_sw_lo", 32'h0);
        check("rst_pending", {31'b0, pend}, 32'h0);
        rd(4'd4, "rst_sw_hi", 32'h0);
        rd(4'd5, "rst_op", 32'h0);
        rd(4'd6, "rst_evt", 32'h0);
        rd(4'd7, "rst_cnt", 32'h0);
        rd(4'd3, "sw_lo_edge6_pre", 32'h0);
        rd(4'd4, "sw_hi_settled", 32'h1F);
        rd(4'd3, "sw_lo_settled", 32'h1F);

        // Glitch on button 1 shorter than D.
        io[11] = 1'b0; step(3); io[11] = 1'b1; step(10);
        rd(4'd6, "glitch_evt", 32'h0);
        rd(4'd7, "glitch_cnt", 32'h0);
        rd(4'd5, "glitch_op", 32'h0);

        // Button 2 held low for 10 cycles.
        io[12] = 1'b0; step(6);
        check("b2_pending_not_yet", {31'b0, pend}, 32'h0);
        rd(4'd6, "b2_evt", 32'h4);
        check("b2_pending_rise", {31'b0, pend}, 32'h1);
        rd(4'd5, "b2_op", 32'h2);
        rd(4'd7, "b2_cnt", 32'h1);
        step(1); io[12] = 1'b1; step(8);
        rd(4'd7, "b2_release_cnt", 32'h1);

        // W1C of event 2: read on the clearing edge shows pre-clear value.
        we = 1'b1; din = 32'h4;
        rd(4'd6, "w1c_pre", 32'h4);
        check("w1c_pending_pre", {31'b0, pend}, 32'h1);
        we = 1'b0; din = 32'h0;
        rd(4'd6, "w1c_post", 32'h0);
        check("w1c_pending_fall", {31'b0, pend}, 32'h0);

        // Buttons 0 and 2 fall together.
        io[10] = 1'b0; io[12] = 1'b0; step(8);
        io[10] = 1'b1; io[12] = 1'b1; step(8);
        rd(4'd5, "dual_op", 32'h0);
        rd(4'd6, "dual_evt", 32'h5);
        rd(4'd7, "dual_cnt", 32'h3);
        rd(4'd9, "unmapped", 32'h0);

        we = 1'b1; din = 32'h7;
        rd(4'd6, "clr_evt_pre", 32'h5);
        rd(4'd7, "clr_cnt_pre", 32'h3);
        we = 1'b0; din = 32'h0;
        rd(4'd7, "clr_cnt_post", 32'h0);

        // Reset two cycles into a switch-5 debounce.
        io[5] = 1'b0; step(8);
        rd(4'd4, "sw5_low", 32'h1E);
        io[5] = 1'b1; step(4);
        rst = 1'b1; step(1); rst = 1'b0;
        rd(4'd4, "rst_mid_e1", 32'h0);
        step(4);
        rd(4'd4, "rst_mid_e6_pre", 32'h0);
        rd(4'd4, "rst_mid_e7", 32'h1F);
        rd(4'd7, "rst_mid_cnt", 32'h0);

        // Wrap test on the single-cycle debounce instance.
        io2 = 13'h1FFF; step(2);
        rst2 = 1'b0; step(4);
        for (int n = 0; n < 21845; n++) begin
            io2[12:10] = 3'b000; step(1);
            io2[12:10] = 3'b111; step(1);
        end
        step(4);
        rd2(4'd7, "wrap_ffff", 32'hFFFF);
        io2[10] = 1'b0; step(1); io2[10] = 1'b1; step(4);
        rd2(4'd7, "wrap_zero", 32'h0);
        rd2(4'd5, "wrap_op", 32'h0);
        io2[10] = 1'b0; step(1); io2[10] = 1'b1; step(4);
        rd2(4'd7, "wrap_one", 32'h1);
        io2[10] = 1'b0; step(1); io2[10] = 1'b1; step(1);
        we2 = 1'b1;
        rd2(4'd7, "clr_press_pre", 32'h1);
        we2 = 1'b0;
        rd2(4'd7, "clr_press_post", 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
